// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_pkg : shared state encoding and defaults for imem_loader      |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t c_idle   = 3'd0;
  localparam state_t c_len_lo = 3'd1;
  localparam state_t c_len_hi = 3'd2;
  localparam state_t c_data   = 3'd3;
  localparam state_t c_csum   = 3'd4;
  localparam state_t c_done   = 3'd5;
  localparam state_t c_error  = 3'd6;

  localparam logic [7:0] c_sync_byte_default = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_timer : reloadable idle-cycle counter, saturates at TIMEOUT_CYC |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module byte_timer #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic reload,
  output logic expired
);

  localparam int                c_cnt_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYC);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || !enable || reload) begin
      r_count <= '0;
    end else if (r_count != c_limit) begin
      r_count <= r_count + c_one;
    end
  end

  assign expired = enable && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader : UART boot loader framing bytes into imem words         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module imem_loader
  import loader_pkg::*;
#(
  parameter int         DEPTH_WORDS = 512,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] SYNC_BYTE   = c_sync_byte_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int                c_idx_w   = $clog2(DEPTH_WORDS) + 1;
  localparam logic [16:0]        c_depth   = 17'(DEPTH_WORDS);
  localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

  state_t             r_state;
  logic [7:0]         r_len_lo;
  logic [7:0]         r_csum;
  logic [c_idx_w-1:0] r_len;
  logic [c_idx_w-1:0] r_word_idx;
  logic [1:0]         r_byte_idx;
  logic [23:0]        r_asm;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_hold;
  logic               r_done;
  logic               r_err;

  logic               w_timer_en;
  logic               w_expired;
  logic [15:0]        w_len;
  logic               w_last_word;

  assign w_timer_en  = (r_state == c_len_lo) || (r_state == c_len_hi) ||
                       (r_state == c_data)   || (r_state == c_csum);
  assign w_len       = {rx_data, r_len_lo};
  assign w_last_word = (r_word_idx + c_idx_one) == r_len;

  byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_byte_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (w_timer_en),
    .reload  (rx_valid),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_idle;
      r_len_lo   <= '0;
      r_csum     <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // A byte landing on the expiry cycle takes priority over the timeout.
      if (w_expired && !rx_valid) begin
        r_state <= c_error;
        r_err   <= 1'b1;
      end else if (rx_valid) begin
        case (r_state)
          c_idle, c_error: begin
            if (rx_data == SYNC_BYTE) begin
              r_state    <= c_len_lo;
              r_err      <= 1'b0;
              r_csum     <= '0;
              r_word_idx <= '0;
              r_byte_idx <= '0;
            end
          end
          c_len_lo: begin
            r_len_lo <= rx_data;
            r_state  <= c_len_hi;
          end
          c_len_hi: begin
            if ((w_len == 16'd0) || ({1'b0, w_len} > c_depth)) begin
              r_state <= c_error;
              r_err   <= 1'b1;
            end else begin
              r_len   <= c_idx_w'(w_len);
              r_state <= c_data;
            end
          end
          c_data: begin
            r_csum     <= r_csum ^ rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_asm[7:0]   <= rx_data;
              2'd1: r_asm[15:8]  <= rx_data;
              2'd2: r_asm[23:16] <= rx_data;
              default: begin
                r_we       <= 1'b1;
                r_wdata    <= {rx_data, r_asm};
                r_addr     <= 32'({r_word_idx, 2'b00});
                r_word_idx <= r_word_idx + c_idx_one;
                if (w_last_word) begin
                  r_state <= c_csum;
                end
              end
            endcase
          end
          c_csum: begin
            if (rx_data == r_csum) begin
              r_state <= c_done;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= c_error;
              r_err   <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader : directed scoreboard bench for imem_loader           |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int          checks   = 0;
  int          errors   = 0;
  int          wr_count = 0;
  int          base;
  logic [31:0] last_addr = 32'hFFFF_FFFF;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] pay [0:511];

  imem_loader #(
    .DEPTH_WORDS (512),
    .TIMEOUT_CYC (16),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_count++;
      last_addr = imem_addr;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected no write",
               imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", imem_addr, mon_e[63:32]);
        chk("wr_data", imem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
    send(d[7:0]);
    send(d[15:8]);
    send(d[23:16]);
    send(d[31:24]);
  endtask

  task automatic send_frame(input int n, input bit bad);
    logic [7:0] cs;
    cs = 8'h00;
    send(8'hA5);
    send(n[7:0]);
    send(n[15:8]);
    if (n >= 1 && n <= 512) begin
      for (int w = 0; w < n; w++) begin
        send_word(32'(w * 4), pay[w]);
        cs ^= pay[w][7:0] ^ pay[w][15:8] ^ pay[w][23:16] ^ pay[w][31:24];
      end
      chk("done_before_csum", {31'b0, done}, 32'd0);
      send(cs ^ {7'b0, bad});
    end
  endtask

  task automatic status(input string tag, input bit d, input bit h, input bit e);
    chk({tag, "_done"}, {31'b0, done}, {31'b0, d});
    chk({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, h});
    chk({tag, "_err"},  {31'b0, err}, {31'b0, e});
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_we"},    {31'b0, imem_we}, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    status(tag, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(2);
    reset_vals("reset");
    rst = 1'b0;

    // Non-sync bytes in IDLE
    send(8'h13); send(8'h00); send(8'h5A);
    tick(2);
    chk("idle_junk_writes", wr_count, 32'd0);
    status("idle_junk", 1'b0, 1'b1, 1'b0);

    // Single word: A5 01 00 13 05 A0 00 B6
    pay[0] = 32'h00A0_0513;
    send_frame(1, 1'b0);
    status("single", 1'b1, 1'b0, 1'b0);
    chk("single_q", 32'(exp_q.size()), 32'd0);
    chk("single_wr_count", wr_count, 32'd1);
    chk("single_last_addr", last_addr, 32'd0);

    // Everything is ignored in DONE
    send(8'hA5); send(8'h01); send(8'h00);
    repeat (5) send(8'hFF);
    tick(2);
    chk("done_ignore_writes", wr_count, 32'd1);
    status("done_ignore", 1'b1, 1'b0, 1'b0);

    // Three words, rx_valid every cycle
    do_reset();
    pay[0] = 32'hDEAD_BEEF; pay[1] = 32'h1234_5678; pay[2] = 32'hA5A5_0001;
    send_frame(3, 1'b0);
    status("three", 1'b1, 1'b0, 1'b0);
    chk("three_q", 32'(exp_q.size()), 32'd0);
    chk("three_wr_count", wr_count, 32'd4);
    chk("three_last_addr", last_addr, 32'd8);

    // Bad checksum, then recovery via sync from ERROR
    do_reset();
    pay[0] = 32'h0102_0304; pay[1] = 32'hF0E0_D0C0;
    send_frame(2, 1'b1);
    status("badcs", 1'b0, 1'b1, 1'b1);
    pay[0] = 32'h7777_1111;
    send_frame(2, 1'b0);
    status("recover", 1'b1, 1'b0, 1'b0);
    chk("recover_q", 32'(exp_q.size()), 32'd0);

    // Length bounds
    do_reset();
    base = wr_count;
    send_frame(0, 1'b0);
    tick(1);
    status("n0", 1'b0, 1'b1, 1'b1);
    chk("n0_writes", wr_count, base);
    send_frame(513, 1'b0);
    tick(1);
    status("n513", 1'b0, 1'b1, 1'b1);
    chk("n513_writes", wr_count, base);
    for (int i = 0; i < 512; i++) pay[i] = $urandom;
    send_frame(512, 1'b0);
    status("n512", 1'b1, 1'b0, 1'b0);
    chk("n512_writes", wr_count, base + 512);
    chk("n512_last_addr", last_addr, 32'h0000_07FC);
    chk("n512_q", 32'(exp_q.size()), 32'd0);

    // Timeout: 16 idle cycles tolerated, the 17th without a byte aborts
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22);
    tick(16);
    chk("to_edge_err", {31'b0, err}, 32'd0);
    tick(1);
    status("to_fire", 1'b0, 1'b1, 1'b1);

    // A byte on the expiry cycle is accepted
    send(8'hA5); send(8'h01); send(8'h00);
    exp_q.push_back({32'd0, 32'h4433_2211});
    send(8'h11); send(8'h22);
    tick(16);
    send(8'h33);
    tick(16);
    send(8'h44);
    chk("to_boundary_err", {31'b0, err}, 32'd0);
    send(8'h44);
    status("to_boundary", 1'b1, 1'b0, 1'b0);
    chk("to_boundary_q", 32'(exp_q.size()), 32'd0);

    // Reset right after a write mid-DATA
    do_reset();
    send(8'hA5); send(8'h03); send(8'h00);
    send_word(32'd0, 32'hAAAA_5555);
    send_word(32'd4, 32'h1357_9BDF);
    rst = 1'b1;
    tick(1);
    reset_vals("midrst");
    rst = 1'b0;
    chk("midrst_q", 32'(exp_q.size()), 32'd0);
    pay[0] = 32'hCAFE_F00D;
    send_frame(1, 1'b0);
    status("after_rst", 1'b1, 1'b0, 1'b0);
    chk("after_rst_last_addr", last_addr, 32'd0);
    chk("after_rst_q", 32'(exp_q.size()), 32'd0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

UART boot loader that sits directly upstream of the 2 KB instruction memory and drives its write port (`write_enable`, address, `data_input`). It takes received bytes from the UART receiver, frames them into little-endian 32-bit instruction words, and writes them sequentially into instruction memory. It holds the CPU core stalled until a complete, checksum-verified image is loaded.

## Interface
- `DEPTH_WORDS`, default 512: instruction memory capacity in 32-bit words.
- `TIMEOUT_CYC`, default 1_000_000: maximum idle clk cycles between bytes once a frame has started.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `imem_we` out 1: instruction memory write enable (one-cycle pulse).
- `imem_addr` out 32: byte address, word-aligned.
- `imem_wdata` out 32: instruction word.
- `cpu_hold` out 1: keeps the core's PC in reset and stalled while high.
- `done` out 1: image loaded and verified.
- `err` out 1: frame aborted (length, checksum or timeout).

One clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- **Frame format:**
  - `SYNC_BYTE`
  - `LEN_LO`, `LEN_HI`: word count N, little-endian, 16 bits.
  - 4·N payload bytes, each word LSB first.
  - `CSUM`: XOR of all 4·N payload bytes.
- **States:**
  - `IDLE`: on a byte equal to `SYNC_BYTE` → `LEN_LO`; any other byte is ignored.
  - `LEN_LO` → `LEN_HI`: on byte arrival.
  - `LEN_HI`: on byte arrival, N=0 or N>`DEPTH_WORDS` → `ERROR`; otherwise → `DATA`.
  - `DATA`: bytes shift into a 32-bit assembler at lane `byte_idx` (0..3).
    - On lane 3, issue a write at `word_idx`.
    - After word N−1 → `CSUM`.
  - `CSUM`: received byte equals the running XOR → `DONE`; otherwise → `ERROR`.
  - `DONE`: terminal until `rst`; all `rx_valid` ignored.
  - `ERROR`: `err`=1. A `SYNC_BYTE` restarts the frame (→ `LEN_LO`), clearing `err`, the checksum, `word_idx` and `byte_idx`.
- **Timeout:** in `LEN_LO`, `LEN_HI`, `DATA` and `CSUM`, an idle counter reloads on each `rx_valid`. When it reaches `TIMEOUT_CYC` → `ERROR`. The counter does not run in `IDLE`, `DONE` or `ERROR`.
- **Address:** `imem_addr` = `word_idx` << 2. `word_idx` width is clog2(`DEPTH_WORDS`)+1 and never wraps, because the `LEN_HI` check prevents it.
- **Outputs:**
  - `cpu_hold` = 1 in every state except `DONE`.
  - `done` = 1 only in `DONE`.
- Memory contents from an aborted frame are not cleared; the next successful frame overwrites them.

## Timing
- **Reset values:** state=`IDLE`, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0. All counters and the checksum are 0.
- `rst` mid-frame aborts the frame immediately. Partially written memory is left as is.
- All outputs are registered.
- **Write pulse:** `imem_we` is high for exactly the one cycle after the cycle in which the 4th byte of a word is sampled. `imem_addr` and `imem_wdata` are valid in that same cycle and hold until the next write.
- Back-to-back `rx_valid` on consecutive cycles must be accepted. This includes a word completion followed immediately by the next word's byte 0; the assembler must not drop it.
- `done` and `cpu_hold` fall (`cpu_hold` 1→0) together, one cycle after the `CSUM` byte is sampled. The last `imem_we` pulse always precedes this.
- **Timeout boundary:** `rx_valid` in the cycle where the counter hits `TIMEOUT_CYC` wins; the byte is accepted and no error is raised.

## Structure
- Shared package `loader_pkg`: state enum (`IDLE`, `LEN_LO`, `LEN_HI`, `DATA`, `CSUM`, `DONE`, `ERROR`) and the `SYNC_BYTE` default.
- One sub-module, `byte_timer`: a reloadable idle counter with `enable`, `reload` and a `expired` output, parameterised by `TIMEOUT_CYC`.
- Everything else (FSM, byte assembler, XOR accumulator, word counter) stays in `imem_loader`.

## Test plan
- **Single word:** send A5, 01, 00, 13, 05, A0, 00, csum=B6.
  - One `imem_we` pulse with addr=0, wdata=32'h00A00513.
  - `done`=1 and `cpu_hold`=0 one cycle after the csum byte.
- **Three words, back-to-back:** `rx_valid` every cycle.
  - Writes at addr 0, 4, 8 with correct data.
  - `done` asserted; no dropped bytes.
- **Bad checksum:** send a valid frame with csum XOR 1.
  - `err`=1, `done`=0, `cpu_hold`=1.
  - A following valid frame reaches `DONE` with `err`=0.
- **Length bounds:**
  - N=0 → `ERROR`, no writes.
  - N=513 → `ERROR`, no writes.
  - N=512 loads fully; last write is at addr 0x7FC.
- **Timeout:** with `TIMEOUT_CYC`=16, stop after 2 payload bytes.
  - `err`=1 after 16 idle cycles.
  - A byte arriving exactly at cycle 16 is accepted instead.
- **Reset behaviour:**
  - Assert `rst` mid-`DATA`: all outputs return to reset values next cycle, state=`IDLE`, and a later frame loads correctly.
  - Bytes other than A5 in `IDLE`, and any byte in `DONE`, cause no writes.
